rv_bpb_ctrl: RTL and testbench

Write-port controller for the 2-bit branch prediction buffer (BPB).
- Sequences read-modify-write counter updates from EX-stage branch resolution.
- Runs a flush sweep that reinitialises every entry, triggered by fence.i or a context switch.
- Arbitrates a CSR/debug write requester onto the same single write port.
- Sits between the EX stage, the CSR unit and the BPB storage; gates ID-stage prediction while the table is inconsistent.

---
 rtl/rv_bp_pkg.sv | 26 ++
 rtl/rv_bpb_sweep.sv | 50 +++++
 rtl/rv_bpb_ctrl.sv | 93 +++++++++
 tb/tb_rv_bpb_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rv_bp_pkg.sv
// rv_bp_pkg: shared types, 2-bit counter encodings and saturating helpers
// for the branch prediction buffer write-port controller.
package rv_bp_pkg;

    localparam int AW_DEF      = 4;
    localparam int ENTRIES_DEF = 16;

    typedef enum logic {
        IDLE,
        SWEEP
    } bpb_state_e;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    function automatic logic [1:0] sat_inc2(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec2(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/rv_bpb_sweep.sv
// rv_bpb_sweep: flush-sweep FSM walking every BPB index once; a flush
// request seen at any time (re)starts the walk from index 0.
module rv_bpb_sweep
    import rv_bp_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int ENTRIES = ENTRIES_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush_req_i,
    output logic          busy_o,
    output logic [AW-1:0] idx_o
);

    bpb_state_e    r_state;
    bpb_state_e    w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;
    logic          w_last;

    assign w_last = (r_idx == AW'(ENTRIES - 1));
    assign busy_o = (r_state == SWEEP);
    assign idx_o  = r_idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // A flush takes precedence over finishing, so a request on the last
    // edge of a sweep starts a fresh one instead of returning to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (flush_req_i) begin
            w_state_nxt = SWEEP;
            w_idx_nxt   = '0;
        end else if (r_state == SWEEP) begin
            w_state_nxt = w_last ? IDLE : SWEEP;
            w_idx_nxt   = w_last ? '0 : r_idx + AW'(1);
        end
    end

endmodule

// File: rtl/rv_bpb_ctrl.sv
// rv_bpb_ctrl: single write port controller for the 2-bit BPB; arbitrates
// sweep > EX counter update > CSR write and forwards the in-flight write.
module rv_bpb_ctrl
    import rv_bp_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int ENTRIES = ENTRIES_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          EX_branch_i,
    input  logic          EX_taken_i,
    input  logic [AW-1:0] EX_addr_i,
    input  logic          flush_req_i,
    input  logic [1:0]    init_val_i,
    input  logic          csr_wvalid_i,
    input  logic [AW-1:0] csr_waddr_i,
    input  logic [1:0]    csr_wdata_i,
    output logic          csr_wready_o,
    output logic [AW-1:0] tbl_raddr_o,
    input  logic [1:0]    tbl_rdata_i,
    output logic          tbl_we_o,
    output logic [AW-1:0] tbl_waddr_o,
    output logic [1:0]    tbl_wdata_o,
    output logic          busy_o,
    output logic          predict_en_o,
    output logic          upd_drop_o
);

    logic          w_busy;
    logic [AW-1:0] w_sweep_addr;
    logic          w_ex_ok;
    logic          w_csr_ok;
    logic [1:0]    w_cur;
    logic [1:0]    w_ex_data;
    logic [AW-1:0] w_waddr_nxt;
    logic [1:0]    w_wdata_nxt;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [1:0]    r_wdata;
    logic          r_drop;
    logic          r_sweep_wr;

    rv_bpb_sweep #(
        .AW      (AW),
        .ENTRIES (ENTRIES)
    ) u_sweep (
        .clk         (clk),
        .rstn        (rstn),
        .flush_req_i (flush_req_i),
        .busy_o      (w_busy),
        .idx_o       (w_sweep_addr)
    );

    assign tbl_raddr_o  = EX_addr_i;
    assign w_ex_ok      = EX_branch_i & ~w_busy & ~flush_req_i;
    assign csr_wready_o = ~w_busy & ~flush_req_i & ~EX_branch_i;
    assign w_csr_ok     = csr_wvalid_i & csr_wready_o;

    // The table only commits on the edge after the output register loads,
    // so a pending write to the same index is newer than the read data.
    assign w_cur     = (r_we && r_waddr == EX_addr_i) ? r_wdata : tbl_rdata_i;
    assign w_ex_data = EX_taken_i ? sat_inc2(w_cur) : sat_dec2(w_cur);

    always_comb begin
        w_waddr_nxt = w_busy ? w_sweep_addr : w_ex_ok ? EX_addr_i : w_csr_ok ? csr_waddr_i : r_waddr;
        w_wdata_nxt = w_busy ? init_val_i : w_ex_ok ? w_ex_data : w_csr_ok ? csr_wdata_i : r_wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= SNT;
            r_drop     <= 1'b0;
            r_sweep_wr <= 1'b0;
        end else begin
            r_we       <= w_busy | w_ex_ok | w_csr_ok;
            r_waddr    <= w_waddr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_drop     <= EX_branch_i & (w_busy | flush_req_i);
            r_sweep_wr <= w_busy;
        end
    end

    assign tbl_we_o     = r_we;
    assign tbl_waddr_o  = r_waddr;
    assign tbl_wdata_o  = r_wdata;
    assign upd_drop_o   = r_drop;
    assign busy_o       = w_busy;
    assign predict_en_o = ~w_busy & ~r_sweep_wr;

endmodule

// File: tb/tb_rv_bpb_ctrl.sv
// tb_rv_bpb_ctrl: directed self-checking bench for rv_bpb_ctrl with a
// behavioural 16x2 table that commits writes one edge after tbl_we_o.
module tb_rv_bpb_ctrl;

    logic       clk;
    logic       rstn;
    logic       EX_branch_i;
    logic       EX_taken_i;
    logic [3:0] EX_addr_i;
    logic       flush_req_i;
    logic [1:0] init_val_i;
    logic       csr_wvalid_i;
    logic [3:0] csr_waddr_i;
    logic [1:0] csr_wdata_i;
    logic       csr_wready_o;
    logic [3:0] tbl_raddr_o;
    logic [1:0] tbl_rdata_i;
    logic       tbl_we_o;
    logic [3:0] tbl_waddr_o;
    logic [1:0] tbl_wdata_o;
    logic       busy_o;
    logic       predict_en_o;
    logic       upd_drop_o;

    logic [1:0] mem [16];
    logic       mem_clr;
    int         n_chk;
    int         n_pass;
    int         nw;

    rv_bpb_ctrl #(.AW(4), .ENTRIES(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .EX_branch_i  (EX_branch_i),
        .EX_taken_i   (EX_taken_i),
        .EX_addr_i    (EX_addr_i),
        .flush_req_i  (flush_req_i),
        .init_val_i   (init_val_i),
        .csr_wvalid_i (csr_wvalid_i),
        .csr_waddr_i  (csr_waddr_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_wready_o (csr_wready_o),
        .tbl_raddr_o  (tbl_raddr_o),
        .tbl_rdata_i  (tbl_rdata_i),
        .tbl_we_o     (tbl_we_o),
        .tbl_waddr_o  (tbl_waddr_o),
        .tbl_wdata_o  (tbl_wdata_o),
        .busy_o       (busy_o),
        .predict_en_o (predict_en_o),
        .upd_drop_o   (upd_drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 2'd0;
        end else if (tbl_we_o) begin
            mem[tbl_waddr_o] <= tbl_wdata_o;
        end
    end

    assign tbl_rdata_i = mem[tbl_raddr_o];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, we, predict_en, waddr, wdata}
    function automatic logic [31:0] st(input logic b, input logic w, input logic p, input int a, input int d);
        return 32'({b, w, p, 4'(a), 2'(d)});
    endfunction

    initial begin
        logic [1:0] fwd_exp [4];
        fwd_exp = '{2'd1, 2'd2, 2'd3, 2'd3};
        n_chk = 0; n_pass = 0; nw = 0;
        rstn = 1'b0; mem_clr = 1'b1;
        EX_branch_i = 0; EX_taken_i = 0; EX_addr_i = 0; flush_req_i = 0; init_val_i = 0;
        csr_wvalid_i = 0; csr_waddr_i = 0; csr_wdata_i = 0;
        repeat (2) tick();
        chk("rst_state", st(busy_o, tbl_we_o, predict_en_o, tbl_waddr_o, tbl_wdata_o), st(0, 0, 1, 0, 0));
        chk("rst_drop", 32'(upd_drop_o), 0);
        chk("rst_wready", 32'(csr_wready_o), 1);
        mem_clr = 1'b0;
        rstn = 1'b1;
        tick();

        // four back-to-back taken updates to index 3 rely on forwarding
        EX_branch_i = 1; EX_taken_i = 1; EX_addr_i = 3;
        #1;
        chk("raddr", 32'(tbl_raddr_o), 3);
        chk("wready_ex", 32'(csr_wready_o), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("fwd%0d", i), st(busy_o, tbl_we_o, predict_en_o, tbl_waddr_o, tbl_wdata_o), st(0, 1, 1, 3, fwd_exp[i]));
        end
        EX_branch_i = 0;
        tick();
        chk("idle_hold", st(busy_o, tbl_we_o, predict_en_o, tbl_waddr_o, tbl_wdata_o), st(0, 0, 1, 3, 3));

        // saturation at both ends on index 5
        EX_branch_i = 1; EX_taken_i = 0; EX_addr_i = 5;
        tick();
        chk("dec_sat0", st(busy_o, tbl_we_o, predict_en_o, tbl_waddr_o, tbl_wdata_o), st(0, 1, 1, 5, 0));
        EX_branch_i = 0;
        csr_wvalid_i = 1; csr_waddr_i = 5; csr_wdata_i = 3;
        #1;
        chk("wready_idle", 32'(csr_wready_o), 1);
        tick();
        chk("csr_set5", st(busy_o, tbl_we_o, predict_en_o, tbl_waddr_o, tbl_wdata_o), st(0, 1, 1, 5, 3));
        csr_wvalid_i = 0;
        repeat (2) tick();
        EX_branch_i = 1; EX_taken_i = 1; EX_addr_i = 5;
        tick();
        chk("inc_sat3", st(busy_o, tbl_we_o, predict_en_o, tbl_waddr_o, tbl_wdata_o), st(0, 1, 1, 5, 3));
        EX_taken_i = 0;
        tick();
        chk("dec_fwd", st(busy_o, tbl_we_o, predict_en_o, tbl_waddr_o, tbl_wdata_o), st(0, 1, 1, 5, 2));
        EX_branch_i = 0;
        tick();

        // CSR stalled behind an EX update, then accepted
        csr_wvalid_i = 1; csr_waddr_i = 9; csr_wdata_i = 2;
        EX_branch_i = 1; EX_taken_i = 0; EX_addr_i = 3;
        #1;
        chk("csr_stall", 32'(csr_wready_o), 0);
        tick();
        chk("ex_first", st(busy_o, tbl_we_o, predict_en_o, tbl_waddr_o, tbl_wdata_o), st(0, 1, 1, 3, 2));
        EX_branch_i = 0;
        #1;
        chk("csr_ready", 32'(csr_wready_o), 1);
        tick();
        chk("csr_write", st(busy_o, tbl_we_o, predict_en_o, tbl_waddr_o, tbl_wdata_o), st(0, 1, 1, 9, 2));
        csr_wvalid_i = 0;
        tick();
        chk("csr_done", 32'(tbl_we_o), 0);

        // full sweep with a dropped EX update in its first cycle
        init_val_i = 1; flush_req_i = 1;
        #1;
        chk("wready_flush", 32'(csr_wready_o), 0);
        tick();
        flush_req_i = 0;
        EX_branch_i = 1; EX_taken_i = 1; EX_addr_i = 3;
        chk("swp_start", st(busy_o, tbl_we_o, predict_en_o, tbl_waddr_o, tbl_wdata_o), st(1, 0, 0, 9, 2));
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k <= 16) chk($sformatf("swp%0d", k), st(busy_o, tbl_we_o, predict_en_o, tbl_waddr_o, tbl_wdata_o), st(k < 16, 1, 0, k - 1, 1));
            else chk("swp_end", st(busy_o, tbl_we_o, predict_en_o, tbl_waddr_o, tbl_wdata_o), st(0, 0, 1, 15, 1));
            if (k == 1) chk("drop_on", 32'(upd_drop_o), 1);
            if (k == 2) chk("drop_off", 32'(upd_drop_o), 0);
            EX_branch_i = 0;
        end

        // flush re-pulsed while idx = 7
        init_val_i = 2; flush_req_i = 1;
        tick();
        flush_req_i = 0;
        for (int k = 1; k <= 26; k++) begin
            tick();
            nw += int'(tbl_we_o);
            chk($sformatf("rst_swp%0d", k), st(busy_o, tbl_we_o, predict_en_o, tbl_waddr_o, tbl_wdata_o),
                st(k < 24, k <= 24, k > 24, (k <= 8) ? k - 1 : (k <= 24) ? k - 9 : 15, 2));
            flush_req_i = (k == 7);
        end
        chk("restart_cnt", 32'(nw), 24);

        // asynchronous reset in the middle of a sweep
        init_val_i = 3; flush_req_i = 1;
        tick();
        flush_req_i = 0;
        repeat (10) tick();
        chk("pre_rst_addr", 32'(tbl_waddr_o), 9);
        rstn = 1'b0;
        #1;
        chk("async_rst", st(busy_o, tbl_we_o, predict_en_o, tbl_waddr_o, tbl_wdata_o), st(0, 0, 1, 0, 0));
        tick();
        rstn = 1'b1;
        nw = 0;
        repeat (20) begin
            tick();
            nw += int'(tbl_we_o) + int'(busy_o);
        end
        chk("no_resume", 32'(nw), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
